// File: rtl/collision_scanner.sv
// collision_scanner
//   Sequential piece/field conflict check. Walks the BLK x BLK piece mask one
//   mask row at a time, fetching the matching field row through a synchronous
//   row-read port and comparing it against the mask row. Reports whether any
//   occupied mask cell collides with an occupied field cell or lies outside
//   the walls/floor. It also reports whether any such cell was out of bounds,
//   and the mask coordinates of the first collision.
//
// Ports
//   clk, resetn        clock (rising edge), asynchronous active-low reset
//   start / busy       query request (taken only when idle) / query in flight
//   blk, blk_x, blk_y  piece mask and signed placement, sampled on acceptance
//   row_rd, row_addr   field row read request
//   row_data           field row contents, valid the cycle after row_rd
//   done               one-cycle pulse; the result outputs are valid
//   conflict, oob      collision found / some colliding cell is out of bounds
//   hit_row, hit_col   mask row/column of the first collision (0 if none)
module collision_scanner #(
   parameter int unsigned FIELD_W    = 10,
   parameter int unsigned FIELD_H    = 20,
   parameter int unsigned BLK        = 4,
   parameter int unsigned XW         = 6,
   parameter int unsigned YW         = 6,
   parameter int unsigned EARLY_EXIT = 0
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   output logic                 busy,
   input  logic [BLK*BLK-1:0]   blk,
   input  logic [XW-1:0]        blk_x,
   input  logic [YW-1:0]        blk_y,
   output logic                 row_rd,
   output logic [YW-1:0]        row_addr,
   input  logic [FIELD_W-1:0]   row_data,
   output logic                 done,
   output logic                 conflict,
   output logic                 oob,
   output logic [YW-1:0]        hit_row,
   output logic [YW-1:0]        hit_col
);

   localparam int unsigned RW = (BLK > 1) ? $clog2(BLK) : 1;
   localparam int unsigned XE = XW + 1;
   localparam int unsigned YE = YW + 1;
   localparam logic [XE-1:0] FieldWV = XE'(FIELD_W);
   localparam logic [YE-1:0] FieldHV = YE'(FIELD_H);

   typedef enum logic [1:0] {StIdle, StFetch, StCmp, StDone} stateT;

   stateT stateQ, stateD;

   logic [BLK*BLK-1:0] blkQ;
   logic [XW-1:0]      blkXQ;
   logic [YW-1:0]      blkYQ;
   logic [RW-1:0]      rowQ;

   // Running results for the query in flight.
   logic               accConflictQ, accConflictD;
   logic               accOobQ, accOobD;
   logic [YW-1:0]      accHitRowQ, accHitRowD;
   logic [YW-1:0]      accHitColQ, accHitColD;

   logic               accept;
   logic               lastRow;
   logic               finish;

   logic signed [YE-1:0] fy;
   logic               fyAbove;
   logic               fyBelow;
   logic               rowInField;

   logic [BLK-1:0]     rowMask;
   logic signed [XE-1:0] fx;
   logic               cellHit;
   logic               cellOob;
   logic               rowHit;
   logic               rowOob;
   logic [YW-1:0]      rowHitCol;

   // ---------------------------------------------------------------------
   // Row geometry: fy is the field row under the current mask row.
   // ---------------------------------------------------------------------
   always_comb begin
      fy         = $signed({blkYQ[YW-1], blkYQ}) + $signed(YE'(rowQ));
      fyAbove    = fy[YE-1];
      fyBelow    = !fy[YE-1] && ($unsigned(fy) >= FieldHV);
      rowInField = !fyAbove && !fyBelow;
      rowMask    = blkQ[int'(rowQ)*BLK +: BLK];
   end

   // ---------------------------------------------------------------------
   // Compare one mask row against row_data. Columns are walked upward so
   // the first hit recorded is the lowest column.
   // ---------------------------------------------------------------------
   always_comb begin
      fx        = '0;
      cellHit   = 1'b0;
      cellOob   = 1'b0;
      rowHit    = 1'b0;
      rowOob    = 1'b0;
      rowHitCol = '0;
      for (int c = 0; c < BLK; c++) begin
         fx      = $signed({blkXQ[XW-1], blkXQ}) + $signed(XE'(c));
         cellHit = 1'b0;
         cellOob = 1'b0;
         if (rowMask[c]) begin
            if (fx[XE-1] || ($unsigned(fx) >= FieldWV) || fyBelow) begin
               cellHit = 1'b1;
               cellOob = 1'b1;
            end else if (!fyAbove) begin
               // Spawn-zone rows (fy < 0) never collide; otherwise look up fx.
               for (int f = 0; f < FIELD_W; f++) begin
                  if ($unsigned(fx) == XE'(f)) begin
                     cellHit = row_data[f];
                  end
               end
            end
         end
         if (cellOob) begin
            rowOob = 1'b1;
         end
         if (cellHit && !rowHit) begin
            rowHitCol = YW'(c);
         end
         if (cellHit) begin
            rowHit = 1'b1;
         end
      end
   end

   // Only the first colliding row (lowest r) sets the hit coordinates.
   always_comb begin
      accConflictD = accConflictQ | rowHit;
      accOobD      = accOobQ | rowOob;
      accHitRowD   = accHitRowQ;
      accHitColD   = accHitColQ;
      if (rowHit && !accConflictQ) begin
         accHitRowD = YW'(rowQ);
         accHitColD = rowHitCol;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stateQ <= StIdle;
      end else begin
         stateQ <= stateD;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------
   assign lastRow = (rowQ == RW'(BLK - 1));

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         StIdle:  if (start) stateD = StFetch;
         StFetch: stateD = StCmp;
         StCmp: begin
            if (lastRow || ((EARLY_EXIT != 0) && rowHit)) begin
               stateD = StDone;
            end else begin
               stateD = StFetch;
            end
         end
         StDone:  stateD = StIdle;
         default: stateD = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      busy     = (stateQ != StIdle);
      done     = (stateQ == StDone);
      row_rd   = (stateQ == StFetch) && rowInField;
      row_addr = row_rd ? fy[YW-1:0] : '0;
   end

   assign accept = (stateQ == StIdle) && start;
   assign finish = (stateQ == StCmp) && (stateD == StDone);

   // ---------------------------------------------------------------------
   // Query operands, row counter, accumulators and visible results
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         blkQ         <= '0;
         blkXQ        <= '0;
         blkYQ        <= '0;
         rowQ         <= '0;
         accConflictQ <= 1'b0;
         accOobQ      <= 1'b0;
         accHitRowQ   <= '0;
         accHitColQ   <= '0;
         conflict     <= 1'b0;
         oob          <= 1'b0;
         hit_row      <= '0;
         hit_col      <= '0;
      end else if (accept) begin
         blkQ         <= blk;
         blkXQ        <= blk_x;
         blkYQ        <= blk_y;
         rowQ         <= '0;
         accConflictQ <= 1'b0;
         accOobQ      <= 1'b0;
         accHitRowQ   <= '0;
         accHitColQ   <= '0;
         conflict     <= 1'b0;
         oob          <= 1'b0;
         hit_row      <= '0;
         hit_col      <= '0;
      end else if (stateQ == StCmp) begin
         accConflictQ <= accConflictD;
         accOobQ      <= accOobD;
         accHitRowQ   <= accHitRowD;
         accHitColQ   <= accHitColD;
         if (finish) begin
            // Results become visible together with done.
            conflict <= accConflictD;
            oob      <= accOobD;
            hit_row  <= accHitRowD;
            hit_col  <= accHitColD;
         end else begin
            rowQ <= rowQ + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_collision_scanner.sv
// Bench for collision_scanner: one fixed-latency instance (dut0) and one
// early-exit instance (dut1), each backed by a registered field RAM model.
module tb_collision_scanner;

   localparam int FW = 10;
   localparam int FH = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetn;
   logic          start0, start1;
   logic [15:0]   blk;
   logic [5:0]    blkX, blkY;

   logic          busy0, rowRd0, done0, conf0, oob0;
   logic [5:0]    rowAddr0, hitRow0, hitCol0;
   logic [FW-1:0] rowData0 = '0;
   logic          busy1, rowRd1, done1, conf1, oob1;
   logic [5:0]    rowAddr1, hitRow1, hitCol1;
   logic [FW-1:0] rowData1 = '0;

   logic [FW-1:0] fieldMem [FH];

   int total = 0;
   int bad   = 0;

   collision_scanner #(.EARLY_EXIT(0)) dut0 (
      .clk(clk), .resetn(resetn), .start(start0), .busy(busy0),
      .blk(blk), .blk_x(blkX), .blk_y(blkY),
      .row_rd(rowRd0), .row_addr(rowAddr0), .row_data(rowData0),
      .done(done0), .conflict(conf0), .oob(oob0), .hit_row(hitRow0), .hit_col(hitCol0)
   );

   collision_scanner #(.EARLY_EXIT(1)) dut1 (
      .clk(clk), .resetn(resetn), .start(start1), .busy(busy1),
      .blk(blk), .blk_x(blkX), .blk_y(blkY),
      .row_rd(rowRd1), .row_addr(rowAddr1), .row_data(rowData1),
      .done(done1), .conflict(conf1), .oob(oob1), .hit_row(hitRow1), .hit_col(hitCol1)
   );

   // Field RAM: data valid the cycle after the read strobe.
   always @(posedge clk) begin
      if (rowRd0 && (int'(rowAddr0) < FH)) rowData0 <= fieldMem[rowAddr0];
      if (rowRd1 && (int'(rowAddr1) < FH)) rowData1 <= fieldMem[rowAddr1];
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clearField();
      for (int i = 0; i < FH; i++) fieldMem[i] = '0;
   endtask

   // Issue one query on dut<sel> and watch it to done (bounded).
   task automatic runQuery(input int sel, input logic [15:0] b, input int bx, input int by,
                           output int lat, output int nRd, output int firstRd);
      blk  = b;
      blkX = bx[5:0];
      blkY = by[5:0];
      if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      lat     = -1;
      nRd     = 0;
      firstRd = -1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc == 1) begin
            start0 = 1'b0;
            start1 = 1'b0;
         end
         if ((sel == 0) ? rowRd0 : rowRd1) begin
            if (nRd == 0) firstRd = int'((sel == 0) ? rowAddr0 : rowAddr1);
            nRd++;
         end
         if ((sel == 0) ? done0 : done1) begin
            lat = cyc;
            break;
         end
      end
   endtask

   typedef struct {
      logic [15:0] blk;
      int          bx;
      int          by;
      int          fRow;
      logic [9:0]  fVal;
      int          nRd;
      int          firstRd;
      int          expC;
      int          expO;
      int          expHr;
      int          expHc;
   } vecT;

   vecT vecs[10];

   int lat, nRd, firstRd, cnt, firstDone;

   initial begin
      vecs[0] = '{16'h0660,  3,  5,  0, 10'h000, 4,  5, 0, 0, 0, 0}; // empty field
      vecs[1] = '{16'h0660,  3,  5,  7, 10'h010, 4,  5, 1, 0, 2, 1}; // field hit
      vecs[2] = '{16'h000F, -1,  0,  0, 10'h000, 4,  0, 1, 1, 0, 0}; // left wall
      vecs[3] = '{16'h000F,  7,  0,  0, 10'h000, 4,  0, 1, 1, 0, 3}; // right wall
      vecs[4] = '{16'h0660,  0, -2,  0, 10'h3FF, 2,  0, 1, 0, 2, 1}; // spawn zone
      vecs[5] = '{16'h0660,  0, 18,  0, 10'h000, 2, 18, 1, 1, 2, 1}; // floor
      vecs[6] = '{16'h0000, -5, 30,  0, 10'h000, 0,  0, 0, 0, 0, 0}; // empty mask
      vecs[7] = '{16'h0001,  9, 19, 19, 10'h200, 1, 19, 1, 0, 0, 0}; // corner cell
      vecs[8] = '{16'h8000,  6, -3,  0, 10'h200, 1,  0, 1, 0, 3, 3}; // last mask cell
      vecs[9] = '{16'h000F,  0, -1,  0, 10'h3FF, 3,  0, 0, 0, 0, 0}; // all in spawn zone

      resetn = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      blk    = '0;
      blkX   = '0;
      blkY   = '0;
      clearField();
      #12;
      chk("reset ctl0", int'({busy0, rowRd0, done0, conf0, oob0}), 0);
      chk("reset addr0", int'(rowAddr0), 0);
      chk("reset hit0", int'({hitRow0, hitCol0}), 0);
      chk("reset ctl1", int'({busy1, rowRd1, done1, conf1, oob1}), 0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Fixed-latency instance, table driven.
      foreach (vecs[i]) begin
         clearField();
         fieldMem[vecs[i].fRow] = vecs[i].fVal;
         runQuery(0, vecs[i].blk, vecs[i].bx, vecs[i].by, lat, nRd, firstRd);
         chk($sformatf("v%0d latency", i), lat, 9);
         chk($sformatf("v%0d reads", i), nRd, vecs[i].nRd);
         if (vecs[i].nRd > 0) chk($sformatf("v%0d first addr", i), firstRd, vecs[i].firstRd);
         chk($sformatf("v%0d conflict", i), int'(conf0), vecs[i].expC);
         chk($sformatf("v%0d oob", i), int'(oob0), vecs[i].expO);
         chk($sformatf("v%0d hit_row", i), int'(hitRow0), vecs[i].expHr);
         chk($sformatf("v%0d hit_col", i), int'(hitCol0), vecs[i].expHc);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d done pulse", i), int'(done0), 0);
         chk($sformatf("v%0d hold", i), int'(conf0), vecs[i].expC);
      end

      // Early-exit instance: hit on mask row 0, then row 1, then no hit.
      clearField();
      runQuery(1, 16'h000F, -1, 0, lat, nRd, firstRd);
      chk("ee row0 latency", lat, 3);
      chk("ee row0 conflict", int'({conf1, oob1}), 3);
      chk("ee row0 hit_col", int'(hitCol1), 0);
      @(posedge clk);
      #1;
      fieldMem[6] = 10'h010;
      runQuery(1, 16'h0660, 3, 5, lat, nRd, firstRd);
      chk("ee row1 latency", lat, 5);
      chk("ee row1 hit", int'({conf1, oob1, hitRow1, hitCol1}), int'({1'b1, 1'b0, 6'd1, 6'd1}));
      @(posedge clk);
      #1;
      clearField();
      runQuery(1, 16'h0660, 3, 5, lat, nRd, firstRd);
      chk("ee none latency", lat, 9);
      chk("ee none conflict", int'(conf1), 0);
      @(posedge clk);
      #1;

      // start held high through busy and the done cycle: exactly one done.
      blk    = 16'h000F;
      blkX   = 6'h3F;
      blkY   = 6'd0;
      start1 = 1'b1;
      cnt       = 0;
      firstDone = -1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc == 2) chk("ee busy", int'(busy1), 1);
         if (done1) begin
            if (cnt == 0) firstDone = cyc;
            cnt++;
         end
         if (cyc == 4) start1 = 1'b0;
      end
      chk("ee single done", cnt, 1);
      chk("ee done cycle", firstDone, 3);

      // Reset mid-scan.
      clearField();
      fieldMem[7] = 10'h010;
      blk    = 16'h0660;
      blkX   = 6'd3;
      blkY   = 6'd5;
      start0 = 1'b1;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc == 1) start0 = 1'b0;
      end
      chk("pre-reset busy", int'(busy0), 1);
      resetn = 1'b0;
      #1;
      chk("mid reset ctl", int'({busy0, rowRd0, done0, conf0, oob0}), 0);
      chk("mid reset regs", int'({rowAddr0, hitRow0, hitCol0}), 0);
      @(negedge clk);
      resetn = 1'b1;
      cnt = 0;
      for (int cyc = 0; cyc < 15; cyc++) begin
         @(posedge clk);
         #1;
         if (done0) cnt++;
      end
      chk("no done after reset", cnt, 0);
      runQuery(0, 16'h0660, 3, 5, lat, nRd, firstRd);
      chk("post-reset latency", lat, 9);
      chk("post-reset result", int'({conf0, oob0, hitRow0, hitCol0}),
          int'({1'b1, 1'b0, 6'd2, 6'd1}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
